// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: drain FSM encoding, data width
// default and result drain mode constants.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  localparam logic MODE_LOOPBACK = 1'b0;
  localparam logic MODE_EXPORT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_V,
    PUSH,
    FIN
  } drain_state_t;

endpackage

// File: rtl/drain_watchdog.sv
// Loadable saturating up-counter; expire flags the all-ones value.
// Shared by the result drain and the IFmap/filter feeders.
module drain_watchdog #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  assign expire = &count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !expire) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/result_psum_drain.sv
// Result buffer drain: pops words and either writes them back to the
// psum buffer or exports them on a valid/ready stream.
module result_psum_drain
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH   = 7,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   mode,
  input  logic [DATA_WIDTH-1:0]  result_buffer_out,
  input  logic                   result_buffer_empty,
  input  logic                   result_buffer_valid,
  output logic                   result_buffer_read_enable,
  output logic [DATA_WIDTH-1:0]  psum_buffer_in,
  output logic                   psum_buffer_wen,
  input  logic                   psum_buffer_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  drain_state_t state, state_nxt;

  logic [COUNT_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0]  hold;
  logic                   mode_q;
  logic                   pushed;
  logic                   error_q;
  logic                   wd_expire;
  logic                   handshake;
  logic                   re_c;
  logic                   wen_c;
  logic                   ov_c;
  logic                   done_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pushed marks the post-handshake cycle in which the count drops
  always_comb begin
    state_nxt = state;
    re_c      = 1'b0;
    wen_c     = 1'b0;
    ov_c      = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        if (!result_buffer_empty) begin
          re_c      = 1'b1;
          state_nxt = WAIT_V;
        end
      end
      WAIT_V: begin
        if (result_buffer_valid) begin
          state_nxt = PUSH;
        end else if (wd_expire) begin
          state_nxt = FIN;
        end
      end
      PUSH: begin
        if (pushed) begin
          state_nxt = (remaining <= COUNT_WIDTH'(1)) ? FIN : REQ;
        end else if (mode_q == MODE_EXPORT) begin
          ov_c = 1'b1;
        end else begin
          wen_c = 1'b1;
        end
      end
      FIN: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign handshake = (wen_c && psum_buffer_ready) || (ov_c && out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      mode_q    <= 1'b0;
      hold      <= '0;
      pushed    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        remaining <= word_count;
        mode_q    <= mode;
        error_q   <= 1'b0;
      end
      if (state == WAIT_V && result_buffer_valid) begin
        hold <= result_buffer_out;
      end
      if (state == WAIT_V && !result_buffer_valid && wd_expire) begin
        error_q <= 1'b1;
      end
      pushed <= (state == PUSH) && !pushed && handshake;
      if (state == PUSH && pushed && remaining != '0) begin
        remaining <= remaining - COUNT_WIDTH'(1);
      end
    end
  end

  drain_watchdog #(
    .WIDTH(TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear     (state != WAIT_V),
    .load      (1'b0),
    .load_value({TIMEOUT_WIDTH{1'b0}}),
    .enable    ((state == WAIT_V) && !result_buffer_valid),
    .expire    (wd_expire)
  );

  assign result_buffer_read_enable = re_c;
  assign psum_buffer_wen           = wen_c;
  assign psum_buffer_in            = wen_c ? hold : '0;
  assign out_valid                 = ov_c;
  assign out_data                  = ov_c ? hold : '0;
  assign busy  = (state == REQ) || (state == WAIT_V) || (state == PUSH);
  assign done  = done_c;
  assign error = error_q;

endmodule
